// File: rtl/systolic_pkg.sv
// Shared sizing defaults, accumulator width helper and FSM encoding for the
// systolic job arbiter slice.
package systolic_pkg;

  localparam int DEF_M          = 6;
  localparam int DEF_K          = 6;
  localparam int DEF_N          = 6;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TIMEOUT    = 64;

  // Full-precision dot-product width for K products of two dw-bit operands.
  function automatic int acc_width(input int dw, input int k);
    return 2 * dw + $clog2(k);
  endfunction

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping.
// The pointer register is owned by the instantiating block.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest active requester wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    idx       = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(ptr_i) + off) % NUM_REQ;
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/systolic_job_arbiter.sv
// Time-shares one systolic array between NUM_REQ requesters: round-robin job
// acceptance, operand latch, start/done handshake, watchdog abort, tagged response.
module systolic_job_arbiter
  import systolic_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int M          = DEF_M,
  parameter int K          = DEF_K,
  parameter int N          = DEF_N,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, K),
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ*M*K*DATA_WIDTH-1:0] req_a_flat,
  input  logic [NUM_REQ*K*N*DATA_WIDTH-1:0] req_b_flat,
  output logic                            arr_start,
  output logic [M*K*DATA_WIDTH-1:0]       arr_a_flat,
  output logic [K*N*DATA_WIDTH-1:0]       arr_b_flat,
  input  logic [M*N*ACC_WIDTH-1:0]        arr_c_flat,
  input  logic                            arr_done,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [ID_W-1:0]                 rsp_id,
  output logic [M*N*ACC_WIDTH-1:0]        rsp_c_flat,
  output logic                            rsp_err,
  output logic                            busy
);

  localparam int A_W   = M * K * DATA_WIDTH;
  localparam int B_W   = K * N * DATA_WIDTH;
  localparam int C_W   = M * N * ACC_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  state_t             state_q;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    id_q;
  logic [A_W-1:0]     a_q;
  logic [B_W-1:0]     b_q;
  logic [C_W-1:0]     c_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               start_q;
  logic               rsp_valid_q;
  logic               err_q;
  logic               busy_q;
  logic               accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr (
    .req_i     (req_valid),
    .ptr_i     (ptr_q),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  // Grant is offered only while idle; reset forces it low along with everything else.
  assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;
  assign accept    = |(req_valid & req_ready);
  assign cnt_d     = cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q     <= req_a_flat[int'(gnt_idx) * A_W +: A_W];
            b_q     <= req_b_flat[int'(gnt_idx) * B_W +: B_W];
            id_q    <= gnt_idx;
            ptr_q   <= gnt_idx;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= LAUNCH;
          end
        end
        LAUNCH: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Done has priority over a watchdog expiry in the same cycle.
          if (arr_done) begin
            c_q         <= arr_c_flat;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_d == CNT_W'(TIMEOUT - 1)) begin
            c_q         <= '0;
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arr_start  = start_q;
  assign arr_a_flat = a_q;
  assign arr_b_flat = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_c_flat = c_q;
  assign rsp_err    = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_systolic_job_arbiter.sv
// Directed bench for systolic_job_arbiter with a behavioural array model that
// multiplies the latched operands and pulses done after a fixed latency.
module tb_systolic_job_arbiter;
  import systolic_pkg::*;

  localparam int NR  = 2;
  localparam int M   = 6;
  localparam int K   = 6;
  localparam int N   = 6;
  localparam int DW  = 16;
  localparam int AW  = acc_width(DW, K);
  localparam int TO  = 64;
  localparam int ASZ = M * K * DW;
  localparam int BSZ = K * N * DW;
  localparam int CSZ = M * N * AW;
  localparam int LAT = 2 * K + M + N;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*ASZ-1:0] req_a_flat;
  logic [NR*BSZ-1:0] req_b_flat;
  logic              arr_start;
  logic [ASZ-1:0]    arr_a_flat;
  logic [BSZ-1:0]    arr_b_flat;
  logic [CSZ-1:0]    arr_c_flat;
  logic              arr_done;
  logic              model_done;
  logic              stray_done;
  logic              model_en;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [0:0]        rsp_id;
  logic [CSZ-1:0]    rsp_c_flat;
  logic              rsp_err;
  logic              busy;

  int n_cmp  = 0;
  int n_bad  = 0;
  int twohot = 0;
  int pend;

  always #5 clk = ~clk;
  assign arr_done = model_done | stray_done;

  systolic_job_arbiter #(
    .NUM_REQ(NR), .M(M), .K(K), .N(N), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a_flat(req_a_flat), .req_b_flat(req_b_flat), .arr_start(arr_start),
    .arr_a_flat(arr_a_flat), .arr_b_flat(arr_b_flat), .arr_c_flat(arr_c_flat),
    .arr_done(arr_done), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_c_flat(rsp_c_flat), .rsp_err(rsp_err), .busy(busy)
  );

  function automatic logic [CSZ-1:0] matmul(input logic [ASZ-1:0] a, input logic [BSZ-1:0] b);
    logic [CSZ-1:0] c;
    logic [AW-1:0]  s;
    c = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++) begin
        s = '0;
        for (int k = 0; k < K; k++)
          s = s + AW'(a[(i*K+k)*DW +: DW]) * AW'(b[(k*N+j)*DW +: DW]);
        c[(i*N+j)*AW +: AW] = s;
      end
    return c;
  endfunction

  // Array model: start seen mid-cycle, done high during the LAT-th cycle after start.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      pend       <= 0;
      model_done <= 1'b0;
      arr_c_flat <= '0;
    end else begin
      model_done <= 1'b0;
      if (arr_start && model_en) begin
        arr_c_flat <= matmul(arr_a_flat, arr_b_flat);
        pend       <= LAT;
      end else if (pend > 0) begin
        pend <= pend - 1;
        if (pend == 1) model_done <= 1'b1;
      end
    end
  end

  always @(negedge clk) if ($countones(req_ready) > 1) twohot <= twohot + 1;

  // Requester r: A = (r+1)*I, B elements e+1+100r row-major, so C = (r+1)*B.
  function automatic logic [ASZ-1:0] a_of(input int r);
    logic [ASZ-1:0] a;
    a = '0;
    for (int i = 0; i < M; i++) a[(i*K+i)*DW +: DW] = DW'(r + 1);
    return a;
  endfunction

  function automatic logic [BSZ-1:0] b_of(input int r);
    logic [BSZ-1:0] b;
    for (int e = 0; e < K*N; e++) b[e*DW +: DW] = DW'(e + 1 + r * 100);
    return b;
  endfunction

  function automatic logic [CSZ-1:0] c_of(input int r, input logic err);
    logic [CSZ-1:0] c;
    c = '0;
    if (!err)
      for (int e = 0; e < M*N; e++) c[e*AW +: AW] = AW'((r + 1) * (e + 1 + r * 100));
    return c;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Compares element-wise and reports the first differing element.
  task automatic check_elems(input string nm, input logic [CSZ-1:0] act,
                             input logic [CSZ-1:0] exp, input int ew, input int ne);
    logic [63:0] mask;
    int idx;
    mask = (64'd1 << ew) - 64'd1;
    idx  = 0;
    for (int e = ne - 1; e >= 0; e--)
      if ((64'(act >> (e*ew)) & mask) !== (64'(exp >> (e*ew)) & mask)) idx = e;
    check($sformatf("%s[%0d]", nm, idx), 64'(act >> (idx*ew)) & mask, 64'(exp >> (idx*ew)) & mask);
  endtask

  task automatic check_all_zero(input string nm);
    check(nm, {55'd0, req_ready, arr_start, rsp_valid, rsp_id, rsp_err, busy,
               |arr_a_flat, |arr_b_flat, |rsp_c_flat}, 64'd0);
  endtask

  // One job from grant to response handshake; enters and leaves just after a posedge.
  task automatic run_job(input logic [NR-1:0] v, input int hold, input logic [NR-1:0] eg,
                         input int eid, input logic eerr, input int elat, input string tag);
    int t;
    @(negedge clk);
    req_valid = v;
    #1;
    check({tag, ".gnt"}, req_ready, eg);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check({tag, ".start"}, {busy, arr_start}, 2'b11);
    check_elems({tag, ".arr_a"}, CSZ'(arr_a_flat), CSZ'(a_of(eid)), DW, M*K);
    check_elems({tag, ".arr_b"}, CSZ'(arr_b_flat), CSZ'(b_of(eid)), DW, K*N);
    @(negedge clk);
    check({tag, ".start_pulse"}, arr_start, 1'b0);
    t = 1;
    while (!rsp_valid && t < TO + LAT + 8) begin
      @(negedge clk);
      t++;
    end
    check({tag, ".lat"}, t, elat);
    check({tag, ".id"}, rsp_id, eid);
    check({tag, ".err"}, rsp_err, eerr);
    check_elems({tag, ".c"}, rsp_c_flat, c_of(eid, eerr), AW, M*N);
    for (int h = 0; h < hold; h++) begin
      req_valid  = '1;
      stray_done = (h == 0);
      @(negedge clk);
      stray_done = 1'b0;
      check({tag, ".bp_hold"}, {rsp_valid, rsp_id, rsp_err, req_ready, arr_start},
            {1'b1, 1'(eid), eerr, 2'b00, 1'b0});
      check_elems({tag, ".bp_c"}, rsp_c_flat, c_of(eid, eerr), AW, M*N);
      check_elems({tag, ".bp_a"}, CSZ'(arr_a_flat), CSZ'(a_of(eid)), DW, M*K);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check({tag, ".to_idle"}, {busy, rsp_valid}, 2'b00);
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    int            hold;
    logic [NR-1:0] gnt;
    int            id;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int t;
    logic seen;
    tbl[0] = '{2'b11, 0, 2'b01, 0};  // identity job, requester 0 first after reset
    tbl[1] = '{2'b11, 0, 2'b10, 1};
    tbl[2] = '{2'b11, 5, 2'b01, 0};  // backpressure
    tbl[3] = '{2'b11, 0, 2'b10, 1};
    tbl[4] = '{2'b10, 0, 2'b10, 1};
    tbl[5] = '{2'b01, 0, 2'b01, 0};
    tbl[6] = '{2'b10, 0, 2'b10, 1};

    rst = 1'b1;
    req_valid = '0; rsp_ready = 1'b0; stray_done = 1'b0; model_en = 1'b1;
    req_a_flat = {a_of(1), a_of(0)};
    req_b_flat = {b_of(1), b_of(0)};
    #1 check_all_zero("reset_outputs");
    req_valid = 2'b11;
    #1 check("reset_ready_gated", req_ready, 2'b00);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++)
      run_job(tbl[i].valid, tbl[i].hold, tbl[i].gnt, tbl[i].id, 1'b0, LAT + 1,
              $sformatf("vec%0d", i));

    model_en = 1'b0;
    run_job(2'b01, 0, 2'b01, 0, 1'b1, TO, "timeout");
    model_en = 1'b1;
    run_job(2'b01, 0, 2'b01, 0, 1'b0, LAT + 1, "after_to");

    // Stray done while idle must not start anything or touch the response.
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    @(negedge clk);
    check("stray_idle", {busy, rsp_valid, arr_start, rsp_err}, 4'b0000);
    check_elems("stray_idle_c", rsp_c_flat, c_of(0, 1'b0), AW, M*N);

    // Continuous contention with rsp_ready held: grants alternate, next grant in first IDLE cycle.
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    #1;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("cont%0d.gnt", j), req_ready, (j % 2 == 0) ? 2'b10 : 2'b01);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!rsp_valid && t < 200);
      check($sformatf("cont%0d.id", j), rsp_id, (j % 2 == 0) ? 1 : 0);
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset while in WAIT after a grant to requester 0.
    @(negedge clk);
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(negedge clk);
    check("pre_rst_wait", {busy, rsp_valid}, 2'b10);
    #2 rst = 1'b1;
    #1 check_all_zero("rst_wait_outputs");
    req_valid = 2'b11;
    #1 check("rst_wait_ready_gated", req_ready, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_rst_gnt", req_ready, 2'b01);
    req_valid = '0;
    seen = 1'b0;
    repeat (LAT + 10) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    check("no_rsp_after_rst", seen, 1'b0);
    run_job(2'b11, 0, 2'b01, 0, 1'b0, LAT + 1, "post_rst_job");

    check("never_two_hot", twohot, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
